// File: rtl/occg_pkg.sv
// occg_pkg: shared definitions for the OCCG checkpoint SRAM loader.
//   - default geometry of the OCCG SRAM (DEPTH / WIDTHS / ADDR_WIDTH / IN_WIDTH)
//   - loader state enum
//   - helpers deriving the beats-per-word count and the beat-counter width
package occg_pkg;

    localparam int OCCG_DEPTH      = 18;
    localparam int OCCG_WIDTHS     = 1920;
    localparam int OCCG_ADDR_WIDTH = 5;
    localparam int OCCG_IN_WIDTH   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } occg_state_t;

    // Number of input beats that make up one SRAM word.
    function automatic int occg_beats(input int widths, input int in_width);
        return widths / in_width;
    endfunction

    // Width of a counter indexing beats 0..beats-1 (at least one bit).
    function automatic int occg_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/occg_beat_packer.sv
// occg_beat_packer: packs consecutive IN_WIDTH beats into one WIDTHS word.
// Beat k of a word lands in bits [k*IN_WIDTH +: IN_WIDTH] (beat 0 = LSBs).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clear        restart packing (counter and partial word cleared)
//   accept       a beat is being accepted this cycle
//   beat_data    the beat being accepted
//   word_next    packed word including the beat accepted this cycle, so the
//                full word is available in the same cycle as the last beat
//   last_beat    the beat accepted this cycle completes the word
module occg_beat_packer
    import occg_pkg::*;
#(
    parameter int WIDTHS   = OCCG_WIDTHS,
    parameter int IN_WIDTH = OCCG_IN_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                accept,
    input  logic [IN_WIDTH-1:0] beat_data,
    output logic [WIDTHS-1:0]   word_next,
    output logic                last_beat
);

    localparam int BEATS = occg_beats(WIDTHS, IN_WIDTH);
    localparam int CNT_W = occg_cnt_width(BEATS);

    logic [CNT_W-1:0] beat_cnt_reg;
    logic             at_last;

    assign at_last   = (beat_cnt_reg == CNT_W'(BEATS - 1));
    assign last_beat = accept && at_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat_cnt_reg <= '0;
        end else if (accept) begin
            beat_cnt_reg <= at_last ? '0 : beat_cnt_reg + 1'b1;
        end
    end

    // One register slot per beat position; only the slot addressed by the
    // beat counter loads, which keeps the write-enable decode per slot.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [IN_WIDTH-1:0] slot_reg;
            logic                sel;

            assign sel = accept && (beat_cnt_reg == CNT_W'(gi));

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    slot_reg <= '0;
                end else if (sel) begin
                    slot_reg <= beat_data;
                end
            end

            assign word_next[gi*IN_WIDTH +: IN_WIDTH] = sel ? beat_data : slot_reg;
        end
    endgenerate

endmodule

// File: rtl/occg_loader.sv
// occg_loader: write-side filler for the OCCG checkpoint SRAM.
// Accepts a valid/ready beat stream, packs BEATS beats per word and writes
// words to SRAM addresses 0..DEPTH-1 in order, one wEn pulse per word.
// Optional feature macro: OCCG_LOADER_CSUM_EN adds the csum output, a
// running XOR of all beats accepted since the last accepted start.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           pulse, begins a load from IDLE or DONE (ignored otherwise)
//   in_data/in_valid/in_ready   input beat stream
//   wEn/wAddr/wData SRAM write port (wData holds the last written word)
//   busy            load in progress (through the cycle of the last wEn)
//   done            level, set after the last word, cleared by start or rst
//   csum            XOR checksum of accepted beats (macro-enabled only)
module occg_loader
    import occg_pkg::*;
#(
    parameter int DEPTH      = OCCG_DEPTH,
    parameter int WIDTHS     = OCCG_WIDTHS,
    parameter int ADDR_WIDTH = OCCG_ADDR_WIDTH,
    parameter int IN_WIDTH   = OCCG_IN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wEn,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [WIDTHS-1:0]     wData,
    output logic                  busy,
    output logic                  done
`ifdef OCCG_LOADER_CSUM_EN
    ,
    output logic [IN_WIDTH-1:0]   csum
`endif
);

    generate
        if (WIDTHS % IN_WIDTH != 0) begin : g_bad_width
            $error("occg_loader: WIDTHS must be a multiple of IN_WIDTH");
        end
        if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_addr
            $error("occg_loader: ADDR_WIDTH too small for DEPTH");
        end
    endgenerate

    occg_state_t           state_reg;
    logic [ADDR_WIDTH-1:0] word_cnt_reg;
    logic                  in_ready_reg;
    logic                  wEn_reg;
    logic [ADDR_WIDTH-1:0] wAddr_reg;
    logic [WIDTHS-1:0]     wData_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic                  accept;
    logic                  start_ok;
    logic                  last_beat;
    logic [WIDTHS-1:0]     word_next;

    // in_ready is only ever high in FILL, so accept implies FILL.
    assign accept   = in_valid && in_ready_reg;
    assign start_ok = start && ((state_reg == IDLE) || (state_reg == DONE));

    occg_beat_packer #(
        .WIDTHS   (WIDTHS),
        .IN_WIDTH (IN_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .accept    (accept),
        .beat_data (in_data),
        .word_next (word_next),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            word_cnt_reg <= '0;
            in_ready_reg <= 1'b0;
            wEn_reg      <= 1'b0;
            wAddr_reg    <= '0;
            wData_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            wEn_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg    <= FILL;
                        word_cnt_reg <= '0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        done_reg     <= 1'b0;
                    end
                end
                FILL: begin
                    // The full word (including this last beat) is captured
                    // straight into the write-data register.
                    if (last_beat) begin
                        state_reg    <= WRITE;
                        in_ready_reg <= 1'b0;
                        wEn_reg      <= 1'b1;
                        wAddr_reg    <= word_cnt_reg;
                        wData_reg    <= word_next;
                    end
                end
                WRITE: begin
                    word_cnt_reg <= word_cnt_reg + 1'b1;
                    if (word_cnt_reg == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg    <= FILL;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready = in_ready_reg;
    assign wEn      = wEn_reg;
    assign wAddr    = wAddr_reg;
    assign wData    = wData_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

`ifdef OCCG_LOADER_CSUM_EN
    logic [IN_WIDTH-1:0] csum_reg;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            csum_reg <= '0;
        end else if (accept) begin
            csum_reg <= csum_reg ^ in_data;
        end
    end

    assign csum = csum_reg;
`endif

endmodule

// File: doc/occg_loader.md
# occg_loader

Write-side filler for the OCCG checkpoint SRAM. It takes a narrow valid/ready beat stream, packs consecutive beats into full WIDTHS-bit checkpoint words, and drives the SRAM write port (wEn/wAddr/wData) sequentially from address 0 to DEPTH-1. The OCCG table can then be loaded at run time instead of through simulation-only file init. It sits between the host/DMA input stream and the OCCG SRAM; search engines keep sole use of the read ports.

## Interface
- DEPTH, 18, number of checkpoint words to load
- WIDTHS, 1920, SRAM word width
- ADDR_WIDTH, 5, SRAM address width; must satisfy 2^ADDR_WIDTH >= DEPTH
- IN_WIDTH, 64, input beat width; WIDTHS % IN_WIDTH == 0 (elaboration error otherwise)

- clk  input  1  clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse, begins a load; ignored unless state is IDLE or DONE
- in_data  input  IN_WIDTH  stream beat
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted at posedge when in_valid && in_ready
- wEn  output  1  SRAM write enable, one-cycle pulse per word
- wAddr  output  ADDR_WIDTH  SRAM write address
- wData  output  WIDTHS  SRAM write data
- busy  output  1  high from the cycle after an accepted start through the cycle of the last wEn
- done  output  1  level, high after the last word is written, cleared by the next accepted start or by rst
- csum  output  IN_WIDTH  running XOR of accepted beats (only with OCCG_LOADER_CSUM_EN)

## Operation
- BEATS = WIDTHS/IN_WIDTH (30 at defaults).
- States: IDLE, FILL, WRITE, DONE.
- IDLE/DONE + start -> FILL. Clear beat_cnt, word_cnt, and packed word. Clear done (and csum).
- FILL: in_ready=1. Each accepted beat k (0..BEATS-1) lands in bits [k*IN_WIDTH +: IN_WIDTH]. Beat 0 is the LSBs. On acceptance of beat BEATS-1 -> WRITE.
- WRITE: in_ready=0. wEn=1, wAddr=word_cnt, wData=packed word, held stable this cycle only. Then word_cnt++. If word_cnt was DEPTH-1 -> DONE, else -> FILL with beat_cnt=0.
- DONE: in_ready=0, done=1. Extra in_valid beats are not accepted.
- in_valid low in FILL: stall indefinitely, no timeout. Partial word is retained.
- start while FILL/WRITE: ignored, no restart.
- start and in_valid in the same IDLE cycle: the beat is not accepted (in_ready=0 in IDLE).
- wData is unchanged outside WRITE (last written word). It is don't-care when wEn=0, but must be deterministic.

## Timing
- Reset values: in_ready=0, wEn=0, wAddr=0, wData=0, busy=0, done=0, csum=0. State=IDLE, counters=0.
- rst mid-load: next cycle is IDLE. The partial word is discarded and no wEn is issued. Already-written SRAM words stay as they are.
- start at cycle t -> in_ready=1 at t+1.
- Last beat of a word accepted at cycle t -> wEn=1 during t+1 (sampled by the SRAM at the end of t+1). in_ready=1 again at t+2.
- With in_valid held high: one word per BEATS+1 cycles. A full load takes DEPTH*(BEATS+1) cycles after the first beat (558 at defaults).
- done rises the cycle after the final wEn. busy falls in the same cycle.

## Configuration
- OCCG_LOADER_CSUM_EN defined: the csum port exists. csum ^= in_data on every accepted beat, cleared on accepted start. It is valid and stable once done=1, so the host can compare it against its own checksum.
- Not defined: the csum port and its register are absent. All other behaviour is identical.

## Structure
- occg_pkg holds:
  - the state enum (IDLE, FILL, WRITE, DONE);
  - the localparam function computing BEATS and beat-counter width;
  - default DEPTH/WIDTHS/ADDR_WIDTH shared with the SRAM instance.
- Sub-module occg_beat_packer holds the beat counter, the indexed-write packing register and the last-beat flag. occg_loader holds the FSM, word counter, write-port registers and optional csum.

## Test plan
- Reset then idle: assert rst 3 cycles with in_valid=1 -> all outputs 0, no beat accepted, no wEn.
- Full load at defaults: start, then 540 beats with beat value = word*30+beat, in_valid continuous. Required:
  - 18 wEn pulses at wAddr 0..17, each 31 cycles apart;
  - word n bits [63:0] = n*30 and bits [1919:1856] = n*30+29;
  - done=1 one cycle after the last wEn; SRAM readback matches.
- Backpressure/gaps: in_valid random 50%. Required: same SRAM contents as the full-load case, in_ready=0 in every WRITE cycle, no beat lost or duplicated.
- start while busy at beat 10 of word 3: load continues unaffected, final word_cnt 18, done once.
- rst at beat 15 of word 5, then a new start and full load: exactly 5 wEn before the reset, no wEn at the reset, then 18 clean writes starting at wAddr 0.
- With OCCG_LOADER_CSUM_EN: stream all beats = 64'hA5A5_A5A5_A5A5_A5A5 -> csum=0 after done (even count 540). Change one beat to 0 -> csum=64'hA5A5_A5A5_A5A5_A5A5.
